seg_scan_driver: RTL
====================

// Module: seg_scan_driver
// PURPOSE
//  Time-multiplexed driver for a bank of NUM_DIGITS common-anode 7-segment digits.
//  - Latches a packed hex value plus per-digit masks, then scans the digits one at a time.
//  - Inserts dead time between digits, suppresses leading zeros and blinks selected digits.
//  - Sits between the CPU-side display register and the board segment/anode pins.
// PARAMETERS
//  NUM_DIGITS    8     number of digits scanned; >= 1
//  SCAN_DIV      1000  clk cycles per digit slot, dead time included; > DEAD_CYCLES
//  DEAD_CYCLES   16    cycles at the start of each slot with all anodes off; 0 = no dead state
//  BLINK_FRAMES  64    full scan frames per blink half-period; >= 1
// PORTS
//  clk          in   1              system clock, rising edge
//  rst          in   1              asynchronous reset, active high
//  load         in   1              one-cycle strobe; captures value and the three masks
//  value        in   4*NUM_DIGITS   hex nibbles; digit i = value[4i+3:4i]; digit 0 is rightmost
//  en_mask      in   NUM_DIGITS     1 = digit enabled
//  dp_mask      in   NUM_DIGITS     1 = decimal point lit
//  blink_mask   in   NUM_DIGITS     1 = digit blinks
//  lz_suppress  in   1              live, not latched; 1 = blank leading zeros
//  seg_n        out  7              segments, active low; bit0 = a ... bit6 = g
//  dp_n         out  1              decimal point, active low
//  an_n         out  NUM_DIGITS     digit select, active low; at most one bit low
//  frame_tick   out  1              one-cycle pulse at the end of each full frame
// BEHAVIOUR
//  Reset (async, immediate) puts the block in this state:
//  - Outputs: an_n all 1, seg_n 7'h7F, dp_n 1, frame_tick 0.
//  - FSM = DEAD, digit index 0, slot counter 0, blink phase = visible.
//  - Shadow and active registers 0 (all digits disabled); pending flag 0.
//  Load:
//  - load=1 writes value and the masks into shadow registers and sets pending.
//  - A second load before commit overwrites the shadow; the newest load wins.
//  Commit:
//  - On the edge that ends the ON phase of digit NUM_DIGITS-1, if pending, shadow copies to active and pending clears.
//  - Commit happens only at that frame boundary, so a frame never tears.
//  - A load in that same cycle goes to shadow and commits at the next boundary.
//  FSM, per slot:
//  - DEAD lasts DEAD_CYCLES cycles; an_n all 1, seg_n 7'h7F, dp_n 1.
//  - ON lasts SCAN_DIV-DEAD_CYCLES cycles and drives the current digit.
//  - At the end of ON the index increments, wrapping NUM_DIGITS-1 -> 0, and the FSM enters DEAD.
//  - If DEAD_CYCLES=0 the FSM goes ON -> ON and DEAD is never entered.
//  - Slot = SCAN_DIV cycles; frame = NUM_DIGITS*SCAN_DIV cycles.
//  frame_tick: high during the last ON cycle of digit NUM_DIGITS-1.
//  Outputs are registers loaded on the FSM transition edge, so there are no glitches.
//  Blanking: in its ON slot, digit i is blank (an_n[i]=1, seg_n 7'h7F, dp_n 1) if any of these hold:
//  - en_mask[i]=0;
//  - blink phase is hidden and blink_mask[i]=1;
//  - lz_suppress=1, i>0, and nibbles i..NUM_DIGITS-1 are all zero. Digit 0 is never suppressed.
//  Otherwise an_n[i]=0, seg_n = hex glyph of nibble i, dp_n = ~dp_mask[i].
//  Blink phase toggles at every BLINK_FRAMES-th frame_tick.
//  Counter widths: $clog2 of each terminal count, minimum 1 bit.
// STRUCTURE
//  seg_pkg holds:
//  - SEG_HEX[16] active-low glyph table: 0=7'b1000000, 1=7'b1111001, ... F=7'b0001110.
//  - SEG_BLANK=7'h7F.
//  - FSM state encoding DEAD/ON.
//  One sub-module, seg_hex_decode: 4-bit nibble -> 7-bit active-low glyph, pure combinational.
//  The top holds the FSM, counters, shadow/active registers, blink phase and lz logic.
// TESTING (NUM_DIGITS=4, SCAN_DIV=8, DEAD_CYCLES=2, BLINK_FRAMES=2)
//  1. Assert rst mid-ON -> same cycle an_n=4'hF, seg_n=7'h7F, dp_n=1, frame_tick=0; no digit lit until a load commits.
//  2. load value=16'h12AF, en=4'hF, dp=4'b0100, then run 2 frames:
//     - digit0 slot: 2 cycles an_n=4'hF, then 6 cycles an_n=4'b1110, seg_n=7'b0001110.
//     - digit2 slot: an_n=4'b1011, seg_n=7'b0100100, dp_n=0.
//     - digit3 slot: an_n=4'b0111, seg_n=7'b1111001.
//  3. lz_suppress=1, value=16'h0030 -> digits 3 and 2 keep an_n=1; digit1 shows 7'b0110000, digit0 shows 7'b1000000.
//     Then value=16'h0000 -> only digit0 lights, showing 7'b1000000.
//  4. Tearing: load 16'h1111 then 16'h2222 during the digit1 slot of a frame showing 16'h0000.
//     - Digits 2 and 3 of that frame still show 0.
//     - From the next digit0 every digit shows 2; 1 never appears.
//  5. blink_mask=4'b0001 -> frame_tick every 32 cycles; digit0 lit 2 frames, blank 2 frames, repeating.
//  6. Random loads for 10k cycles, checked every cycle:
//     - popcount(~an_n) <= 1.
//     - an_n=4'hF in the first 2 cycles of every slot.
//     - seg_n=7'h7F whenever an_n=4'hF.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared constants for the 7-segment scan driver: glyph table, blank pattern, FSM encoding.
package seg_pkg;

   localparam int unsigned SEG_W = 7;

   // All segments off (active low).
   localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;

   // Active-low hex glyphs, bit0 = a ... bit6 = g.
   localparam logic [SEG_W-1:0] SEG_HEX [16] = '{
      7'b1000000,  // 0
      7'b1111001,  // 1
      7'b0100100,  // 2
      7'b0110000,  // 3
      7'b0011001,  // 4
      7'b0010010,  // 5
      7'b0000010,  // 6
      7'b1111000,  // 7
      7'b0000000,  // 8
      7'b0010000,  // 9
      7'b0001000,  // A
      7'b0000011,  // b
      7'b1000110,  // C
      7'b0100001,  // d
      7'b0000110,  // E
      7'b0001110   // F
   };

   typedef enum logic {
      ST_DEAD = 1'b0,
      ST_ON   = 1'b1
   } scan_state_e;

   // Counter width for a terminal count, never narrower than one bit.
   function automatic int unsigned clog2_min1(input int unsigned x);
      return (x <= 1) ? 1 : $clog2(x);
   endfunction

endpackage

// File: rtl/seg_hex_decode.sv
// Nibble to active-low 7-segment glyph, purely combinational.
module seg_hex_decode
   import seg_pkg::*;
(
   input  logic [3:0]       nibble,
   output logic [SEG_W-1:0] seg_n_c
);

   // Table lookup into the shared glyph ROM.
   always_comb begin
      seg_n_c = SEG_HEX[nibble];
   end

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed common-anode 7-segment driver with dead time, blanking,
// leading-zero suppression, blinking and frame-aligned double buffering.
module seg_scan_driver
   import seg_pkg::*;
#(
   parameter int unsigned NUM_DIGITS   = 8,
   parameter int unsigned SCAN_DIV     = 1000,
   parameter int unsigned DEAD_CYCLES  = 16,
   parameter int unsigned BLINK_FRAMES = 64
)(
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    load,
   input  logic [4*NUM_DIGITS-1:0] value,
   input  logic [NUM_DIGITS-1:0]   en_mask,
   input  logic [NUM_DIGITS-1:0]   dp_mask,
   input  logic [NUM_DIGITS-1:0]   blink_mask,
   input  logic                    lz_suppress,
   output logic [SEG_W-1:0]        seg_n,
   output logic                    dp_n,
   output logic [NUM_DIGITS-1:0]   an_n,
   output logic                    frame_tick
);

   localparam int unsigned ON_CYCLES = SCAN_DIV - DEAD_CYCLES;
   localparam int unsigned VAL_W     = 4 * NUM_DIGITS;
   localparam int unsigned CNT_W     = clog2_min1(SCAN_DIV);
   localparam int unsigned IDX_W     = clog2_min1(NUM_DIGITS);
   localparam int unsigned BLK_W     = clog2_min1(BLINK_FRAMES);
   localparam bit          HAS_DEAD  = (DEAD_CYCLES != 0);

   localparam logic [CNT_W-1:0] DEAD_LAST = CNT_W'((DEAD_CYCLES == 0) ? 0 : DEAD_CYCLES - 1);
   localparam logic [CNT_W-1:0] ON_LAST   = CNT_W'(ON_CYCLES - 1);
   localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
   localparam logic [BLK_W-1:0] BLK_LAST  = BLK_W'(BLINK_FRAMES - 1);

   scan_state_e             state_q, state_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic [IDX_W-1:0]        idx_q, idx_d;
   logic                    end_frame_c;

   logic [BLK_W-1:0]        blk_cnt_q, blk_cnt_d;
   logic                    hidden_q, hidden_d;

   logic                    pending_q, pending_d;
   logic [VAL_W-1:0]        sh_value_q, sh_value_d;
   logic [NUM_DIGITS-1:0]   sh_en_q, sh_en_d;
   logic [NUM_DIGITS-1:0]   sh_dp_q, sh_dp_d;
   logic [NUM_DIGITS-1:0]   sh_blink_q, sh_blink_d;
   logic [VAL_W-1:0]        act_value_q, act_value_d;
   logic [NUM_DIGITS-1:0]   act_en_q, act_en_d;
   logic [NUM_DIGITS-1:0]   act_dp_q, act_dp_d;
   logic [NUM_DIGITS-1:0]   act_blink_q, act_blink_d;

   logic [NUM_DIGITS-1:0]   lz_blank_c;
   logic [3:0]              nib_c;
   logic [SEG_W-1:0]        glyph_c;
   logic                    lit_c;

   logic [SEG_W-1:0]        seg_n_q, seg_n_d;
   logic                    dp_n_q, dp_n_d;
   logic [NUM_DIGITS-1:0]   an_n_q, an_n_d;
   logic                    frame_tick_q, frame_tick_d;

   // Slot FSM: DEAD then ON per digit, advancing the digit index at the end of ON.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q + CNT_W'(1);
      idx_d       = idx_q;
      end_frame_c = 1'b0;
      case (state_q)
         ST_DEAD: begin
            if (!HAS_DEAD || (cnt_q == DEAD_LAST)) begin
               state_d = ST_ON;
               cnt_d   = '0;
            end
         end
         ST_ON: begin
            if (cnt_q == ON_LAST) begin
               cnt_d       = '0;
               state_d     = HAS_DEAD ? ST_DEAD : ST_ON;
               idx_d       = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
               end_frame_c = (idx_q == IDX_LAST);
            end
         end
         default: begin
            state_d = ST_DEAD;
            cnt_d   = '0;
         end
      endcase
   end

   // Shadow capture on load; shadow to active only at the frame boundary.
   always_comb begin
      sh_value_d  = sh_value_q;
      sh_en_d     = sh_en_q;
      sh_dp_d     = sh_dp_q;
      sh_blink_d  = sh_blink_q;
      act_value_d = act_value_q;
      act_en_d    = act_en_q;
      act_dp_d    = act_dp_q;
      act_blink_d = act_blink_q;
      pending_d   = pending_q;
      if (end_frame_c && pending_q) begin
         act_value_d = sh_value_q;
         act_en_d    = sh_en_q;
         act_dp_d    = sh_dp_q;
         act_blink_d = sh_blink_q;
         pending_d   = 1'b0;
      end
      if (load) begin
         sh_value_d = value;
         sh_en_d    = en_mask;
         sh_dp_d    = dp_mask;
         sh_blink_d = blink_mask;
         pending_d  = 1'b1;
      end
   end

   // Blink phase flips every BLINK_FRAMES frames.
   always_comb begin
      blk_cnt_d = blk_cnt_q;
      hidden_d  = hidden_q;
      if (end_frame_c) begin
         if (blk_cnt_q == BLK_LAST) begin
            blk_cnt_d = '0;
            hidden_d  = ~hidden_q;
         end else begin
            blk_cnt_d = blk_cnt_q + BLK_W'(1);
         end
      end
   end

   // Leading-zero mask: digit i blanks when it and all higher nibbles are zero; digit 0 never.
   always_comb begin : lz_calc
      logic upper_zero;
      upper_zero = 1'b1;
      lz_blank_c = '0;
      for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
         upper_zero    = upper_zero & (act_value_d[4*i +: 4] == 4'h0);
         lz_blank_c[i] = lz_suppress & upper_zero;
      end
   end

   // Select the nibble for the digit about to be shown.
   always_comb begin
      nib_c = act_value_d[{idx_d, 2'b00} +: 4];
   end

   seg_hex_decode u_hex (
      .nibble  (nib_c),
      .seg_n_c (glyph_c)
   );

   // Next output values, computed from next state so the pins change only at slot edges.
   always_comb begin
      lit_c        = (state_d == ST_ON) && act_en_d[idx_d]
                     && !(hidden_d && act_blink_d[idx_d]) && !lz_blank_c[idx_d];
      an_n_d       = '1;
      seg_n_d      = SEG_BLANK;
      dp_n_d       = 1'b1;
      frame_tick_d = (state_d == ST_ON) && (idx_d == IDX_LAST) && (cnt_d == ON_LAST);
      if (lit_c) begin
         an_n_d[idx_d] = 1'b0;
         seg_n_d       = glyph_c;
         dp_n_d        = ~act_dp_d[idx_d];
      end
   end

   // State, buffers and output registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ST_DEAD;
         cnt_q        <= '0;
         idx_q        <= '0;
         blk_cnt_q    <= '0;
         hidden_q     <= 1'b0;
         pending_q    <= 1'b0;
         sh_value_q   <= '0;
         sh_en_q      <= '0;
         sh_dp_q      <= '0;
         sh_blink_q   <= '0;
         act_value_q  <= '0;
         act_en_q     <= '0;
         act_dp_q     <= '0;
         act_blink_q  <= '0;
         seg_n_q      <= SEG_BLANK;
         dp_n_q       <= 1'b1;
         an_n_q       <= '1;
         frame_tick_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         idx_q        <= idx_d;
         blk_cnt_q    <= blk_cnt_d;
         hidden_q     <= hidden_d;
         pending_q    <= pending_d;
         sh_value_q   <= sh_value_d;
         sh_en_q      <= sh_en_d;
         sh_dp_q      <= sh_dp_d;
         sh_blink_q   <= sh_blink_d;
         act_value_q  <= act_value_d;
         act_en_q     <= act_en_d;
         act_dp_q     <= act_dp_d;
         act_blink_q  <= act_blink_d;
         seg_n_q      <= seg_n_d;
         dp_n_q       <= dp_n_d;
         an_n_q       <= an_n_d;
         frame_tick_q <= frame_tick_d;
      end
   end

   assign seg_n      = seg_n_q;
   assign dp_n       = dp_n_q;
   assign an_n       = an_n_q;
   assign frame_tick = frame_tick_q;

endmodule
